// File: rtl/hazard_unit.sv
// Hazard detection and forwarding unit for the 5-stage RV32I pipeline.
// Tracks register addresses from Decode to Writeback and issues stall, flush and forward selects.
module hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              ResultSrcE0,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    logic [REG_AW-1:0] rs1e_q, rs1e_d;
    logic [REG_AW-1:0] rs2e_q, rs2e_d;
    logic [REG_AW-1:0] rde_q,  rde_d;
    logic [REG_AW-1:0] rdm_q,  rdm_d;
    logic [REG_AW-1:0] rdw_q,  rdw_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              lw_stall;
    logic              flush_e;

    // Memory result wins over Writeback because it is the younger producer.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdm,
        input logic [REG_AW-1:0] rdw,
        input logic              wr_m,
        input logic              wr_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (wr_m && (rdm == rs)) begin
                sel = 2'b10;
            end else if (wr_w && (rdw == rs)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        lw_stall = ResultSrcE0 && (rde_q != '0) && ((Rs1D == rde_q) || (Rs2D == rde_q));
        flush_e  = lw_stall || PCSrcE;

        StallF    = lw_stall;
        StallD    = lw_stall;
        FlushD    = PCSrcE;
        FlushE    = flush_e;
        ForwardAE = fwd_sel(rs1e_q, rdm_q, rdw_q, RegWriteM, RegWriteW);
        ForwardBE = fwd_sel(rs2e_q, rdm_q, rdw_q, RegWriteM, RegWriteW);
    end

    always_comb begin
        rs1e_d = Rs1D;
        rs2e_d = Rs2D;
        rde_d  = RdD;
        if (flush_e) begin
            rs1e_d = '0;
            rs2e_d = '0;
            rde_d  = '0;
        end
        rdm_d = rde_q;
        rdw_d = rdm_q;

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (lw_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (PCSrcE && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1e_q      <= '0;
            rs2e_q      <= '0;
            rde_q       <= '0;
            rdm_q       <= '0;
            rdw_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            rs1e_q      <= rs1e_d;
            rs2e_q      <= rs2e_d;
            rde_q       <= rde_d;
            rdm_q       <= rdm_d;
            rdw_q       <= rdw_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random traffic against a pipeline model.
module tb_hazard_unit;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE;

    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount, FlushCount;

    logic        s_StallF, s_StallD, s_FlushD, s_FlushE;
    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic [1:0]  s_StallCount, s_FlushCount;

    int passed = 0;
    int total  = 0;

    hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_unit #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .StallCount(s_StallCount), .FlushCount(s_FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one record per pipeline slot, index 0 = Execute, 1 = Memory, 2 = Writeback.
    typedef struct {
        int rs1;
        int rs2;
        int rd;
    } slot_t;
    slot_t pipe [3];
    int n_stall, n_flush;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
        n_stall = 0;
        n_flush = 0;
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic bit m_lw();
        return ResultSrcE0 && pipe[0].rd != 0 && (int'(Rs1D) == pipe[0].rd || int'(Rs2D) == pipe[0].rd);
    endfunction

    function automatic int m_fwd(input int rs);
        if (rs == 0) return 0;
        if (RegWriteM && pipe[1].rd == rs) return 2;
        if (RegWriteW && pipe[2].rd == rs) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_now();
        bit lw;
        lw = m_lw();
        chk("StallF",     int'(StallF),     int'(lw));
        chk("StallD",     int'(StallD),     int'(lw));
        chk("FlushD",     int'(FlushD),     int'(PCSrcE));
        chk("FlushE",     int'(FlushE),     int'(lw | PCSrcE));
        chk("ForwardAE",  int'(ForwardAE),  m_fwd(pipe[0].rs1));
        chk("ForwardBE",  int'(ForwardBE),  m_fwd(pipe[0].rs2));
        chk("StallCount", int'(StallCount), sat(n_stall, 65535));
        chk("FlushCount", int'(FlushCount), sat(n_flush, 65535));
        chk("sat_FlushE",     int'(s_FlushE),     int'(lw | PCSrcE));
        chk("sat_ForwardAE",  int'(s_ForwardAE),  m_fwd(pipe[0].rs1));
        chk("sat_StallCount", int'(s_StallCount), sat(n_stall, 3));
        chk("sat_FlushCount", int'(s_FlushCount), sat(n_flush, 3));
    endtask

    task automatic tick();
        bit lw;
        lw = m_lw();
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (lw || PCSrcE) pipe[0] = '{0, 0, 0};
        else              pipe[0] = '{int'(Rs1D), int'(Rs2D), int'(RdD)};
        if (lw)     n_stall++;
        if (PCSrcE) n_flush++;
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int r1, input int r2, input int rd,
                         input bit ld, input bit wm, input bit ww, input bit br);
        Rs1D = 5'(r1); Rs2D = 5'(r2); RdD = 5'(rd);
        ResultSrcE0 = ld; RegWriteM = wm; RegWriteW = ww; PCSrcE = br;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_ForwardAE",  int'(ForwardAE),    0);
        chk("rst_ForwardBE",  int'(ForwardBE),    0);
        chk("rst_StallCount", int'(StallCount),   0);
        chk("rst_FlushCount", int'(FlushCount),   0);
        chk("rst_sat_Flush",  int'(s_FlushCount), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int sat_exp [5];
        sat_exp = '{1, 2, 3, 3, 3};
        reset = 1'b1;
        Rs1D = '0; Rs2D = '0; RdD = '0;
        ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_now();
        chk("rst_StallF", int'(StallF), 0);
        reset = 1'b0;

        // Load-use: lw x5 enters Execute, dependent instruction waits one cycle.
        drive(0, 0, 5, 0, 0, 0, 0); check_now(); tick();
        drive(5, 0, 6, 1, 0, 0, 0); check_now();
        chk("lu_StallF", int'(StallF), 1);
        chk("lu_FlushD", int'(FlushD), 0);
        tick();
        drive(5, 0, 6, 0, 1, 0, 0); check_now();
        chk("lu_no_stall", int'(StallF), 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0); check_now();
        chk("lu_fwd_wb", int'(ForwardAE), 1);
        chk("lu_cnt",    int'(StallCount), 1);
        tick();

        // Forward priority: x7 produced by both Memory and Writeback.
        drive(7, 7, 7, 0, 0, 0, 0); tick();
        drive(7, 7, 7, 0, 0, 0, 0); tick();
        drive(7, 7, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 1, 0); check_now();
        chk("prio_A_mem", int'(ForwardAE), 2);
        chk("prio_B_mem", int'(ForwardBE), 2);
        drive(0, 0, 0, 0, 0, 1, 0); check_now();
        chk("prio_A_wb", int'(ForwardAE), 1);
        tick();

        // x0 guard: load writing x0 never stalls, x0 never forwards.
        drive(0, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();
        drive(0, 0, 0, 1, 1, 1, 0); check_now();
        chk("x0_stall", int'(StallF), 0);
        chk("x0_fwd",   int'(ForwardAE), 0);
        tick();

        // Branch flush, then coincident load-use and branch.
        drive(3, 4, 9, 0, 0, 0, 1); check_now();
        chk("br_FlushE", int'(FlushE), 1);
        chk("br_StallF", int'(StallF), 0);
        tick();
        drive(0, 0, 8, 0, 0, 0, 0); check_now(); tick();
        drive(0, 8, 2, 1, 0, 0, 1); check_now();
        chk("co_StallD", int'(StallD), 1);
        chk("co_FlushD", int'(FlushD), 1);
        tick();
        check_now();

        // Saturation of the 2-bit counters, then reset in the middle of traffic.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(i + 1, 0, i + 1, 0, 0, 0, 1);
            tick();
            chk("sat_seq", int'(s_FlushCount), sat_exp[i]);
        end
        drive(1, 2, 3, 0, 0, 0, 0); tick();
        drive(3, 3, 4, 0, 1, 1, 0); tick();
        do_reset();
        drive(3, 4, 0, 1, 1, 1, 0); check_now();

        // Random traffic on a small register range so hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 4) == 0));
            check_now();
            if ($urandom_range(0, 79) == 0) do_reset();
            else tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
